// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receive controller:
// register map, STATUS layout, write masks, deframer states.
package ps2_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_RAW    = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int ST_VALID = 0;
  localparam int ST_ERR   = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_INH   = 3;
  localparam int ST_CNT   = 4;

  localparam logic [7:0] WR_POP = 8'h02;
  localparam logic [7:0] WR_CLR = 8'h04;

  localparam int FRAME_LEN = 11;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY,
    S_STOP
  } dfr_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises both PS/2 lines, deglitches the clock and
// emits a one-cycle pulse on each accepted clock fall.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2clk,
  input  logic i_ps2data,
  output logic o_fall,
  output logic o_data
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          r_c1;
  logic          r_c2;
  logic          r_d1;
  logic          r_d2;
  logic          r_filt;
  logic [CW-1:0] r_cnt;
  logic          r_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c1   <= 1'b1;
      r_c2   <= 1'b1;
      r_d1   <= 1'b1;
      r_d2   <= 1'b1;
      r_filt <= 1'b1;
      r_cnt  <= '0;
      r_fall <= 1'b0;
    end else begin
      r_c1   <= i_ps2clk;
      r_c2   <= r_c1;
      r_d1   <= i_ps2data;
      r_d2   <= r_d1;
      r_fall <= 1'b0;
      if (r_c2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= r_c2;
        r_cnt  <= '0;
        r_fall <= ~r_c2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_fall = r_fall;
  assign o_data = r_d2;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receiver with scan-code FIFO and 2-bit register port.
// Define PS2_BREAK_FILTER_EN to drop E0 prefixes and F0-break pairs.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_AW     = 3,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       I_CLK,
  input  logic       I_RST,
  input  logic [1:0] I_ADDR,
  input  logic       I_WRITE,
  input  logic [7:0] I_WRDATA,
  output logic [7:0] O_RDDATA,
  inout  wire        IO_PS2CLK,
  inout  wire        IO_PS2DATA
);

`ifdef PS2_BREAK_FILTER_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    BIT_LAST = 3'(FRAME_LEN - 4);

  logic w_fall;
  logic w_data;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .i_clk    (I_CLK),
    .i_rst    (I_RST),
    .i_ps2clk (IO_PS2CLK),
    .i_ps2data(IO_PS2DATA),
    .o_fall   (w_fall),
    .o_data   (w_data)
  );

  dfr_state_t      r_state;
  logic [2:0]      r_bit;
  logic [7:0]      r_sh;
  logic            r_par;
  logic [TW-1:0]   r_tmo;
  logic            r_push;
  logic [7:0]      r_pdata;
  logic [7:0]      r_raw;
  logic            r_brk;
  logic            r_err;
  logic            r_ovf;
  logic [7:0]      r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp;
  logic [FIFO_AW-1:0] r_rp;
  logic [FIFO_AW:0]   r_cnt;

  logic w_full;
  logic w_empty;
  logic w_wr_st;
  logic w_pop;
  logic w_clr;
  logic w_push;
  logic [7:0] w_status;

  assign w_full  = r_cnt[FIFO_AW];
  assign w_empty = (r_cnt == '0);
  assign w_wr_st = I_WRITE && (I_ADDR == ADDR_STATUS);
  assign w_pop   = w_wr_st && |(I_WRDATA & WR_POP) && !w_empty;
  assign w_clr   = w_wr_st && |(I_WRDATA & WR_CLR);
  assign w_push  = r_push && !w_full;

  assign IO_PS2CLK  = w_full ? 1'b0 : 1'bz;
  assign IO_PS2DATA = 1'bz;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_tmo   <= '0;
      r_push  <= 1'b0;
      r_pdata <= '0;
      r_raw   <= '0;
      r_brk   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_push <= 1'b0;
      if (w_clr) r_err <= 1'b0;
      if (r_state == S_IDLE || w_fall) r_tmo <= '0;
      else                             r_tmo <= r_tmo + 1'b1;
      unique case (r_state)
        S_IDLE: if (w_fall) begin
          if (!w_data) begin
            r_state <= S_SHIFT;
            r_bit   <= '0;
          end else if (!w_full) begin
            // while full our own hold-low falls with data idle high
            r_err <= 1'b1;
            r_brk <= 1'b0;
          end
        end
        S_SHIFT: if (w_fall) begin
          r_sh  <= {w_data, r_sh[7:1]};
          r_bit <= r_bit + 1'b1;
          if (r_bit == BIT_LAST) r_state <= S_PARITY;
        end
        S_PARITY: if (w_fall) begin
          r_par   <= w_data;
          r_state <= S_STOP;
        end
        S_STOP: if (w_fall) begin
          r_state <= S_IDLE;
          if (w_data && ^{r_sh, r_par}) begin
            r_raw   <= r_sh;
            r_pdata <= r_sh;
            if (!BRK_EN) begin
              r_push <= 1'b1;
            end else if (r_sh == CODE_BRK) begin
              r_brk <= 1'b1;
            end else if (r_sh != CODE_EXT) begin
              r_brk  <= 1'b0;
              r_push <= !r_brk;
            end
          end else begin
            r_err <= 1'b1;
            r_brk <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (r_state != S_IDLE && !w_fall && r_tmo == TMO_LAST) begin
        r_state <= S_IDLE;
        r_err   <= 1'b1;
        r_brk   <= 1'b0;
      end
    end
  end

  always_ff @(posedge I_CLK) begin
    if (w_push) r_mem[r_wp] <= r_pdata;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_clr)            r_ovf <= 1'b0;
      if (r_push && w_full) r_ovf <= 1'b1;
    end
  end

  always_comb begin
    w_status            = '0;
    w_status[ST_VALID]  = !w_empty;
    w_status[ST_ERR]    = r_err;
    w_status[ST_OVF]    = r_ovf;
    w_status[ST_INH]    = w_full;
    w_status[7:ST_CNT]  = 4'(r_cnt);
  end

  always_comb begin
    O_RDDATA = 8'h00;
    case (I_ADDR)
      ADDR_STATUS: O_RDDATA = w_status;
      ADDR_DATA:   O_RDDATA = w_empty ? 8'h00 : r_mem[r_rp];
      ADDR_RAW:    O_RDDATA = r_raw;
      default:     O_RDDATA = 8'h00;
    endcase
  end

endmodule
